// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and RAM-side signals around mem_port_arbiter.
// master = core/RAM side, slave = the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-3:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a shared single-port sync RAM with 1-cycle read latency.
// Default: fixed data priority with fetch starvation guard; ARB_ROUND_ROBIN_EN selects round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] PEND_NONE = 2'd0;
  localparam logic [1:0] PEND_I    = 2'd1;
  localparam logic [1:0] PEND_D    = 2'd2;

  logic [1:0] r_pend;
  logic       w_i_win;
  logic       w_i_gnt;
  logic       w_d_gnt;
  logic       w_unused;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // On contention the requester that did not win last time goes first.
  assign w_i_win = bus.i_req & (~bus.d_req | r_last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_last_d <= 1'b0;
    else if (w_i_gnt) r_last_d <= 1'b0;
    else if (w_d_gnt) r_last_d <= 1'b1;
  end
`else
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve;

  assign w_i_win = bus.i_req & (~bus.d_req | (r_starve == LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_starve <= '0;
    else if (~bus.i_req | w_i_gnt)   r_starve <= '0;
    else if (r_starve != LIMIT)      r_starve <= r_starve + 1'b1;
  end
`endif

  // Grants are masked while reset is held so every output reads 0.
  assign w_i_gnt = w_i_win & ~rst;
  assign w_d_gnt = bus.d_req & ~w_i_win & ~rst;

  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.ram_en    = w_i_gnt | w_d_gnt;
  assign bus.ram_we    = {4{w_d_gnt & bus.d_we}};
  assign bus.ram_addr  = w_i_gnt ? bus.i_addr[ADDR_W-1:2] :
                         w_d_gnt ? bus.d_addr[ADDR_W-1:2] : '0;
  assign bus.ram_wdata = rst ? '0 : bus.d_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_pend <= PEND_NONE;
    else if (w_i_gnt)               r_pend <= PEND_I;
    else if (w_d_gnt & ~bus.d_we)   r_pend <= PEND_D;
    else                            r_pend <= PEND_NONE;
  end

  assign bus.i_rvalid = (r_pend == PEND_I);
  assign bus.d_rvalid = (r_pend == PEND_D);
  assign bus.i_rdata  = bus.i_rvalid ? bus.ram_rdata : '0;
  assign bus.d_rdata  = bus.d_rvalid ? bus.ram_rdata : '0;
  assign bus.busy     = (r_pend != PEND_NONE);

  assign w_unused = ^{bus.i_addr[31:ADDR_W], bus.i_addr[1:0],
                      bus.d_addr[31:ADDR_W], bus.d_addr[1:0]};
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [DATA_W-1:0] mem [0:255];
  logic [9:0]        exp_i;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_we[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = '0;
    mem[0]   = 32'h11;
    mem[1]   = 32'h22;
    mem[2]   = 32'h33;
    mem[4]   = 32'hA5A5_5A5A;
    mem[255] = 32'h55AA_33CC;
    bus.ram_rdata = '0;
    bus.i_req = 1'b1; bus.i_addr = 32'h10;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset held with a fetch pending: everything must read 0
    #1;
    chk("rst_i_gnt",  32'(bus.i_gnt),  0);
    chk("rst_ram_en", 32'(bus.ram_en), 0);
    chk("rst_busy",   32'(bus.busy),   0);
    tick();
    rst = 1'b0;
    #1;
    chk("rmr_i_gnt",    32'(bus.i_gnt),    1);
    chk("rmr_ram_addr", 32'(bus.ram_addr), 32'h4);
    #1;
    rst = 1'b1;
    bus.i_req = 1'b0;
    #1;
    chk("rmr_ram_en_rst", 32'(bus.ram_en), 0);
    tick();
    chk("rmr_i_rvalid", 32'(bus.i_rvalid), 0);
    chk("rmr_i_rdata",  bus.i_rdata,       0);
    chk("rmr_busy",     32'(bus.busy),     0);
    chk("rmr_d_rvalid", 32'(bus.d_rvalid), 0);
    rst = 1'b0;

    // Fetch-only stream
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    #1;
    chk("f0_i_gnt", 32'(bus.i_gnt), 1);
    tick();
    bus.i_addr = 32'h4;
    #1;
    chk("f1_i_gnt",    32'(bus.i_gnt),    1);
    chk("f1_i_rvalid", 32'(bus.i_rvalid), 1);
    chk("f1_i_rdata",  bus.i_rdata,       32'h11);
    tick();
    bus.i_addr = 32'h8;
    #1;
    chk("f2_i_gnt",    32'(bus.i_gnt),    1);
    chk("f2_i_rdata",  bus.i_rdata,       32'h22);
    chk("f2_d_rvalid", 32'(bus.d_rvalid), 0);
    tick();
    bus.i_req = 1'b0;
    #1;
    chk("f3_i_gnt",    32'(bus.i_gnt),    0);
    chk("f3_i_rvalid", 32'(bus.i_rvalid), 1);
    chk("f3_i_rdata",  bus.i_rdata,       32'h33);
    tick();
    chk("f4_busy", 32'(bus.busy), 0);

    // Store followed by load of the same word
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("st_d_gnt",     32'(bus.d_gnt),    1);
    chk("st_ram_we",    32'(bus.ram_we),   32'hF);
    chk("st_ram_addr",  32'(bus.ram_addr), 32'h10);
    chk("st_ram_wdata", bus.ram_wdata,     32'hDEAD_BEEF);
    tick();
    bus.d_we = 1'b0;
    #1;
    chk("ld_d_gnt",    32'(bus.d_gnt),    1);
    chk("ld_ram_we",   32'(bus.ram_we),   0);
    chk("st_d_rvalid", 32'(bus.d_rvalid), 0);
    chk("st_busy",     32'(bus.busy),     0);
    tick();
    bus.d_req = 1'b0;
    #1;
    chk("ld_d_rvalid", 32'(bus.d_rvalid), 1);
    chk("ld_d_rdata",  bus.d_rdata,       32'hDEAD_BEEF);
    chk("ld_i_rvalid", 32'(bus.i_rvalid), 0);
    tick();

    // Contention from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_i = 10'b10_1010_1010;
`else
    exp_i = 10'b10_0001_0000;
`endif
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("ct%0d_i_gnt", k), 32'(bus.i_gnt), 32'(exp_i[k]));
      chk($sformatf("ct%0d_d_gnt", k), 32'(bus.d_gnt), 32'(!exp_i[k]));
      if (k > 0) begin
        chk($sformatf("ct%0d_i_rvalid", k), 32'(bus.i_rvalid), 32'(exp_i[k-1]));
        chk($sformatf("ct%0d_rdata", k), bus.i_rdata | bus.d_rdata,
            exp_i[k-1] ? 32'h11 : 32'h22);
      end
      tick();
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    #1;
    chk("ct_last_i_rvalid", 32'(bus.i_rvalid), 32'(exp_i[9]));
    chk("ct_last_busy",     32'(bus.busy),     1);
    tick();

    // Address masking: only bits [9:2] reach the RAM
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'hFFFF_F403;
    #1;
    chk("am0_ram_addr", 32'(bus.ram_addr), 32'h00);
    tick();
    bus.d_addr = 32'hFFFF_F3FE;
    #1;
    chk("am0_d_rdata",  bus.d_rdata,       32'h11);
    chk("am1_ram_addr", 32'(bus.ram_addr), 32'hFF);
    tick();
    bus.d_req = 1'b0;
    #1;
    chk("am1_d_rdata", bus.d_rdata, 32'h55AA_33CC);
    tick();
    chk("idle_ram_en", 32'(bus.ram_en), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
